// File: rtl/turn_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : turn_sequencer_pkg
//  Purpose  : Shared states, checker/game result codes and status bit map
//  Revision : 1.0  initial release
// ============================================================================
package turn_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START       = 3'd1,
        HUMAN_WAIT  = 3'd2,
        HUMAN_CHECK = 3'd3,
        AI_WAIT     = 3'd4,
        OVER        = 3'd5,
        FAULT       = 3'd6
    } state_t;

    // Move checker result codes; anything with bit 2 set is illegal
    localparam logic [2:0] c_CHK_OK         = 3'd0;
    localparam logic [2:0] c_CHK_NO_MOVE    = 3'd1;
    localparam logic [2:0] c_CHK_MUST_JUMP  = 3'd2;
    localparam logic [2:0] c_CHK_MORE_JUMPS = 3'd3;

    localparam logic [1:0] c_GAME_NONE  = 2'd0;
    localparam logic [1:0] c_GAME_BLACK = 2'd1;
    localparam logic [1:0] c_GAME_WHITE = 2'd2;
    localparam logic [1:0] c_GAME_DRAW  = 2'd3;

    localparam int c_STATUS_W            = 13;
    localparam int c_ST_BLACK_TO_PLAY    = 0;
    localparam int c_ST_WHITE_TO_PLAY    = 1;
    localparam int c_ST_DRAW_OFFER       = 2;
    localparam int c_ST_BLACK_WINS       = 3;
    localparam int c_ST_WHITE_WINS       = 4;
    localparam int c_ST_DRAW_GAME        = 5;
    localparam int c_ST_NORMAL_WAIT      = 6;
    localparam int c_ST_PLAYER_MUST_JUMP = 7;
    localparam int c_ST_MORE_JUMPS       = 8;
    localparam int c_ST_UNRECOVERABLE    = 9;
    localparam int c_ST_DID_NOT_MOVE     = 10;
    localparam int c_ST_NEW_GAME         = 11;
    localparam int c_ST_USER_TURN_DONE   = 12;

    function automatic logic [c_STATUS_W-1:0] result_mask(input logic [1:0] gr);
        logic [c_STATUS_W-1:0] m;
        m = '0;
        case (gr)
            c_GAME_BLACK: m[c_ST_BLACK_WINS] = 1'b1;
            c_GAME_WHITE: m[c_ST_WHITE_WINS] = 1'b1;
            c_GAME_DRAW:  m[c_ST_DRAW_GAME]  = 1'b1;
            default:      m = '0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
//  Module   : btn_edge
//  Purpose  : Rising-edge detector for a level button, blind to held presses
//  Revision : 1.0  initial release
// ============================================================================
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic r_prev;
    logic r_armed;

    // Armed only after the button has been seen low, so a press held through reset is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= btn;
            r_armed <= r_armed | ~btn;
        end
    end

    assign rise = btn & ~r_prev & r_armed;

endmodule
`default_nettype wire

// File: rtl/turn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : turn_sequencer
//  Purpose  : Human (black) vs AI (white) turn FSM driving checker/AI/LEDs
//  Revision : 1.0  initial release
// ============================================================================
module turn_sequencer
    import turn_sequencer_pkg::*;
#(
    parameter int AI_TIMEOUT = 50_000_000,
    parameter int TW         = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_game_btn,
    input  logic                  turn_done_btn,
    input  logic                  draw_btn,
    input  logic                  chk_done,
    input  logic [2:0]            chk_result,
    input  logic [1:0]            game_result,
    input  logic                  ai_done,
    input  logic                  ai_draw_accept,
    output logic                  chk_start,
    output logic                  ai_start,
    output logic [c_STATUS_W-1:0] status
);

    localparam logic [TW-1:0] c_TIMER_LAST = TW'(AI_TIMEOUT - 1);

    logic [2:0] w_btn;
    logic [2:0] w_rise;
    logic       w_new_game;
    logic       w_turn_done;
    logic       w_draw;

    assign w_btn = {draw_btn, turn_done_btn, new_game_btn};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_edge u_btn_edge (
            .clk  (clk),
            .rst  (rst),
            .btn  (w_btn[i]),
            .rise (w_rise[i])
        );
    end

    assign w_new_game  = w_rise[0];
    assign w_turn_done = w_rise[1];
    assign w_draw      = w_rise[2];

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_draw_pending;
    logic                  w_draw_pending_nxt;
    logic [TW-1:0]         r_timer;
    logic [TW-1:0]         w_timer_nxt;
    logic [c_STATUS_W-1:0] r_status;
    logic [c_STATUS_W-1:0] w_status_nxt;
    logic                  r_chk_start;
    logic                  w_chk_start_nxt;
    logic                  r_ai_start;
    logic                  w_ai_start_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_draw_pending <= 1'b0;
            r_timer        <= '0;
            r_status       <= '0;
            r_chk_start    <= 1'b0;
            r_ai_start     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_draw_pending <= w_draw_pending_nxt;
            r_timer        <= w_timer_nxt;
            r_status       <= w_status_nxt;
            r_chk_start    <= w_chk_start_nxt;
            r_ai_start     <= w_ai_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_draw_pending_nxt = r_draw_pending;
        w_timer_nxt        = r_timer;
        w_status_nxt       = '0;
        w_chk_start_nxt    = 1'b0;
        w_ai_start_nxt     = 1'b0;

        // new_game behaves identically in every state and overrides everything else
        if (w_new_game) begin
            w_status_nxt[c_ST_NEW_GAME] = 1'b1;
            w_state_nxt                 = START;
            w_draw_pending_nxt          = 1'b0;
            w_timer_nxt                 = '0;
        end else begin
            case (r_state)
                START: begin
                    w_status_nxt[c_ST_BLACK_TO_PLAY] = 1'b1;
                    w_status_nxt[c_ST_NORMAL_WAIT]   = 1'b1;
                    w_state_nxt                      = HUMAN_WAIT;
                end
                HUMAN_WAIT: begin
                    if (w_turn_done) begin
                        w_status_nxt[c_ST_USER_TURN_DONE] = 1'b1;
                        w_chk_start_nxt                   = 1'b1;
                        w_state_nxt                       = HUMAN_CHECK;
                    end
                    if (w_draw) begin
                        w_status_nxt[c_ST_DRAW_OFFER] = 1'b1;
                        w_draw_pending_nxt            = 1'b1;
                    end
                end
                HUMAN_CHECK: begin
                    if (chk_done) begin
                        case (chk_result)
                            c_CHK_OK: begin
                                if (game_result != c_GAME_NONE) begin
                                    w_status_nxt = result_mask(game_result);
                                    w_state_nxt  = OVER;
                                end else begin
                                    w_status_nxt[c_ST_WHITE_TO_PLAY] = 1'b1;
                                    w_ai_start_nxt                   = 1'b1;
                                    w_timer_nxt                      = '0;
                                    w_state_nxt                      = AI_WAIT;
                                end
                            end
                            c_CHK_NO_MOVE: begin
                                w_status_nxt[c_ST_DID_NOT_MOVE] = 1'b1;
                                w_state_nxt                     = HUMAN_WAIT;
                            end
                            c_CHK_MUST_JUMP: begin
                                w_status_nxt[c_ST_PLAYER_MUST_JUMP] = 1'b1;
                                w_state_nxt                         = HUMAN_WAIT;
                            end
                            c_CHK_MORE_JUMPS: begin
                                w_status_nxt[c_ST_MORE_JUMPS] = 1'b1;
                                w_state_nxt                   = HUMAN_WAIT;
                            end
                            default: begin
                                w_status_nxt[c_ST_UNRECOVERABLE] = 1'b1;
                                w_state_nxt                      = FAULT;
                            end
                        endcase
                    end
                end
                AI_WAIT: begin
                    // ai_done takes precedence over a timeout landing in the same cycle
                    if (ai_done) begin
                        w_draw_pending_nxt = 1'b0;
                        if (r_draw_pending && ai_draw_accept) begin
                            w_status_nxt[c_ST_DRAW_GAME] = 1'b1;
                            w_state_nxt                  = OVER;
                        end else if (game_result != c_GAME_NONE) begin
                            w_status_nxt = result_mask(game_result);
                            w_state_nxt  = OVER;
                        end else begin
                            w_status_nxt[c_ST_BLACK_TO_PLAY] = 1'b1;
                            w_status_nxt[c_ST_NORMAL_WAIT]   = 1'b1;
                            w_state_nxt                      = HUMAN_WAIT;
                        end
                    end else if (r_timer == c_TIMER_LAST) begin
                        w_status_nxt[c_ST_UNRECOVERABLE] = 1'b1;
                        w_state_nxt                      = FAULT;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    assign status    = r_status;
    assign chk_start = r_chk_start;
    assign ai_start  = r_ai_start;

endmodule
`default_nettype wire

// File: tb/tb_turn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_turn_sequencer
//  Purpose  : Self-checking bench for turn_sequencer (AI_TIMEOUT = 8)
//  Revision : 1.0  initial release
// ============================================================================
module tb_turn_sequencer;
    import turn_sequencer_pkg::*;

    localparam logic [12:0] M_BLK  = 13'd1 << c_ST_BLACK_TO_PLAY;
    localparam logic [12:0] M_WTP  = 13'd1 << c_ST_WHITE_TO_PLAY;
    localparam logic [12:0] M_DOFF = 13'd1 << c_ST_DRAW_OFFER;
    localparam logic [12:0] M_BW   = 13'd1 << c_ST_BLACK_WINS;
    localparam logic [12:0] M_WW   = 13'd1 << c_ST_WHITE_WINS;
    localparam logic [12:0] M_DG   = 13'd1 << c_ST_DRAW_GAME;
    localparam logic [12:0] M_NW   = 13'd1 << c_ST_NORMAL_WAIT;
    localparam logic [12:0] M_PMJ  = 13'd1 << c_ST_PLAYER_MUST_JUMP;
    localparam logic [12:0] M_MJA  = 13'd1 << c_ST_MORE_JUMPS;
    localparam logic [12:0] M_ERR  = 13'd1 << c_ST_UNRECOVERABLE;
    localparam logic [12:0] M_DNM  = 13'd1 << c_ST_DID_NOT_MOVE;
    localparam logic [12:0] M_NG   = 13'd1 << c_ST_NEW_GAME;
    localparam logic [12:0] M_UTD  = 13'd1 << c_ST_USER_TURN_DONE;

    logic        clk;
    logic        rst;
    logic        new_game_btn;
    logic        turn_done_btn;
    logic        draw_btn;
    logic        chk_done;
    logic [2:0]  chk_result;
    logic [1:0]  game_result;
    logic        ai_done;
    logic        ai_draw_accept;
    logic        chk_start;
    logic        ai_start;
    logic [12:0] status;

    turn_sequencer #(.AI_TIMEOUT(8), .TW(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .new_game_btn   (new_game_btn),
        .turn_done_btn  (turn_done_btn),
        .draw_btn       (draw_btn),
        .chk_done       (chk_done),
        .chk_result     (chk_result),
        .game_result    (game_result),
        .ai_done        (ai_done),
        .ai_draw_accept (ai_draw_accept),
        .chk_start      (chk_start),
        .ai_start       (ai_start),
        .status         (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record = inputs held for one cycle plus the registered outputs after that edge
    typedef struct {
        logic        ng, td, dr, cd;
        logic [2:0]  cr;
        logic [1:0]  gr;
        logic        ad, ada, rs;
        logic [12:0] st;
        logic        cs, ai;
        state_t      es;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t v(input logic ng, input logic td, input logic dr, input logic cd,
                               input logic [2:0] cr, input logic [1:0] gr, input logic ad,
                               input logic ada, input logic rs, input logic [12:0] st,
                               input logic cs, input logic ai, input state_t es);
        vec_t r;
        r.ng = ng; r.td = td; r.dr = dr; r.cd = cd; r.cr = cr; r.gr = gr;
        r.ad = ad; r.ada = ada; r.rs = rs; r.st = st; r.cs = cs; r.ai = ai; r.es = es;
        return r;
    endfunction

    task automatic check(input string tag);
        vec_t e;
        e = exp_q.pop_front();
        n_tests++;
        if (status !== e.st || chk_start !== e.cs || ai_start !== e.ai) begin
            n_fail++;
            $display("FAIL %s outputs: got status=%h chk_start=%b ai_start=%b, want status=%h chk_start=%b ai_start=%b",
                     tag, status, chk_start, ai_start, e.st, e.cs, e.ai);
        end
        n_tests++;
        if (dut.r_state !== e.es) begin
            n_fail++;
            $display("FAIL %s state: got %0d, want %0d", tag, int'(dut.r_state), int'(e.es));
        end
    endtask

    task automatic step(input string tag, input vec_t x);
        @(negedge clk);
        new_game_btn   = x.ng;
        turn_done_btn  = x.td;
        draw_btn       = x.dr;
        chk_done       = x.cd;
        chk_result     = x.cr;
        game_result    = x.gr;
        ai_done        = x.ad;
        ai_draw_accept = x.ada;
        rst            = x.rs;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        rst = 1'b1; new_game_btn = 1'b0; turn_done_btn = 1'b0; draw_btn = 1'b0;
        chk_done = 1'b0; chk_result = '0; game_result = '0; ai_done = 1'b0; ai_draw_accept = 1'b0;

        //           ng td dr cd cr    gr    ad ada rs status          cs ai state
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 1, 13'd0,          0, 0, IDLE));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 1, 13'd0,          0, 0, IDLE));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 13'd0,          0, 0, IDLE));
        tbl.push_back(v(1, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_NG,           0, 0, START));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_BLK | M_NW,   0, 0, HUMAN_WAIT));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 13'd0,          0, 0, HUMAN_WAIT));
        tbl.push_back(v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD,          1, 0, HUMAN_CHECK));
        tbl.push_back(v(0, 0, 0, 1, 3'd2, 2'd0, 0, 0, 0, M_PMJ,          0, 0, HUMAN_WAIT));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 13'd0,          0, 0, HUMAN_WAIT));
        tbl.push_back(v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD,          1, 0, HUMAN_CHECK));
        tbl.push_back(v(0, 0, 0, 1, 3'd1, 2'd0, 0, 0, 0, M_DNM,          0, 0, HUMAN_WAIT));
        tbl.push_back(v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD,          1, 0, HUMAN_CHECK));
        tbl.push_back(v(0, 0, 0, 1, 3'd3, 2'd0, 0, 0, 0, M_MJA,          0, 0, HUMAN_WAIT));
        tbl.push_back(v(0, 0, 0, 1, 3'd4, 2'd0, 0, 0, 0, 13'd0,          0, 0, HUMAN_WAIT));
        tbl.push_back(v(0, 1, 1, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD | M_DOFF, 1, 0, HUMAN_CHECK));
        tbl.push_back(v(0, 0, 1, 1, 3'd0, 2'd0, 0, 0, 0, M_WTP,          0, 1, AI_WAIT));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 13'd0,          0, 0, AI_WAIT));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 1, 1, 0, M_DG,           0, 0, OVER));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 13'd0,          0, 0, OVER));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd1, 1, 0, 0, 13'd0,          0, 0, OVER));
        tbl.push_back(v(1, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_NG,           0, 0, START));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_BLK | M_NW,   0, 0, HUMAN_WAIT));
        tbl.push_back(v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD,          1, 0, HUMAN_CHECK));
        tbl.push_back(v(0, 0, 0, 1, 3'd0, 2'd0, 0, 0, 0, M_WTP,          0, 1, AI_WAIT));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 1, 1, 0, M_BLK | M_NW,   0, 0, HUMAN_WAIT));
        tbl.push_back(v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD,          1, 0, HUMAN_CHECK));
        tbl.push_back(v(0, 0, 0, 1, 3'd0, 2'd1, 0, 0, 0, M_BW,           0, 0, OVER));
        tbl.push_back(v(1, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_NG,           0, 0, START));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_BLK | M_NW,   0, 0, HUMAN_WAIT));
        tbl.push_back(v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD,          1, 0, HUMAN_CHECK));
        tbl.push_back(v(0, 0, 0, 1, 3'd0, 2'd0, 0, 0, 0, M_WTP,          0, 1, AI_WAIT));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd2, 1, 0, 0, M_WW,           0, 0, OVER));
        tbl.push_back(v(1, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_NG,           0, 0, START));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_BLK | M_NW,   0, 0, HUMAN_WAIT));
        tbl.push_back(v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD,          1, 0, HUMAN_CHECK));
        tbl.push_back(v(0, 0, 0, 1, 3'd6, 2'd0, 0, 0, 0, M_ERR,          0, 0, FAULT));
        tbl.push_back(v(1, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_NG,           0, 0, START));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_BLK | M_NW,   0, 0, HUMAN_WAIT));
        tbl.push_back(v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD,          1, 0, HUMAN_CHECK));
        tbl.push_back(v(0, 0, 0, 1, 3'd0, 2'd3, 0, 0, 0, M_DG,           0, 0, OVER));
        tbl.push_back(v(1, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_NG,           0, 0, START));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_BLK | M_NW,   0, 0, HUMAN_WAIT));

        for (int i = 0; i < tbl.size(); i++) step($sformatf("tbl%0d", i), tbl[i]);

        // AI timeout: error exactly 8 cycles after ai_start, later ai_done ignored
        step("to_td",  v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD, 1, 0, HUMAN_CHECK));
        step("to_ok",  v(0, 0, 0, 1, 3'd0, 2'd0, 0, 0, 0, M_WTP, 0, 1, AI_WAIT));
        for (int k = 0; k < 7; k++) step("to_wait", v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 13'd0, 0, 0, AI_WAIT));
        step("to_err", v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_ERR, 0, 0, FAULT));
        step("to_ign", v(0, 0, 0, 0, 3'd0, 2'd2, 1, 0, 0, 13'd0, 0, 0, FAULT));
        step("to_ng",  v(1, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_NG, 0, 0, START));
        step("to_st",  v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_BLK | M_NW, 0, 0, HUMAN_WAIT));

        // ai_done on the last timer cycle beats the timeout
        step("tw_td",  v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD, 1, 0, HUMAN_CHECK));
        step("tw_ok",  v(0, 0, 0, 1, 3'd0, 2'd0, 0, 0, 0, M_WTP, 0, 1, AI_WAIT));
        for (int k = 0; k < 7; k++) step("tw_wait", v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 13'd0, 0, 0, AI_WAIT));
        step("tw_ai",  v(0, 0, 0, 0, 3'd0, 2'd0, 1, 0, 0, M_BLK | M_NW, 0, 0, HUMAN_WAIT));

        // new_game overrides a same-cycle chk_done, then an ai_done
        step("ab_td",  v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD, 1, 0, HUMAN_CHECK));
        step("ab_chk", v(1, 0, 0, 1, 3'd0, 2'd0, 0, 0, 0, M_NG, 0, 0, START));
        step("ab_st",  v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_BLK | M_NW, 0, 0, HUMAN_WAIT));
        step("ab_td2", v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD, 1, 0, HUMAN_CHECK));
        step("ab_ok",  v(0, 0, 0, 1, 3'd0, 2'd0, 0, 0, 0, M_WTP, 0, 1, AI_WAIT));
        step("ab_ai",  v(1, 0, 0, 0, 3'd0, 2'd1, 1, 0, 0, M_NG, 0, 0, START));
        step("ab_st2", v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_BLK | M_NW, 0, 0, HUMAN_WAIT));

        // Reset in AI_WAIT with buttons held: nothing until they are released and re-pressed
        step("rs_td",  v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD, 1, 0, HUMAN_CHECK));
        step("rs_ok",  v(0, 0, 0, 1, 3'd0, 2'd0, 0, 0, 0, M_WTP, 0, 1, AI_WAIT));
        step("rs_on",  v(1, 1, 0, 0, 3'd0, 2'd1, 1, 0, 1, 13'd0, 0, 0, IDLE));
        step("rs_on2", v(1, 1, 0, 0, 3'd0, 2'd0, 0, 0, 1, 13'd0, 0, 0, IDLE));
        step("rs_hld", v(1, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, 13'd0, 0, 0, IDLE));
        step("rs_hl2", v(1, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, 13'd0, 0, 0, IDLE));
        step("rs_rel", v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 13'd0, 0, 0, IDLE));
        step("rs_ng",  v(1, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_NG, 0, 0, START));
        step("rs_st",  v(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_BLK | M_NW, 0, 0, HUMAN_WAIT));
        step("rs_td2", v(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, M_UTD, 1, 0, HUMAN_CHECK));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 SHALL have parameter AI_TIMEOUT, default 50_000_000, giving the maximum cycles allowed in AI_WAIT before a fault.
REQ-002 SHALL have parameter TW, default 26, giving the timeout counter width.
REQ-003 SHALL have ports: clk in 1, the single clock, all logic on its rising edge.
REQ-004 SHALL have ports: rst in 1, a synchronous active-high reset.
REQ-005 SHALL have ports: new_game_btn, turn_done_btn and draw_btn, each in 1, as level player buttons.
REQ-006 SHALL have ports: chk_done in 1, a 1-cycle pulse from the move checker.
REQ-007 SHALL have ports: chk_result in 3, valid with chk_done: 0 OK, 1 NO_MOVE, 2 MUST_JUMP, 3 MORE_JUMPS, 4-7 ILLEGAL.
REQ-008 SHALL have ports: game_result in 2, sampled with chk_done or ai_done: 0 none, 1 black wins, 2 white wins, 3 draw.
REQ-009 SHALL have ports: ai_done in 1 (a 1-cycle pulse, the AI move is applied) and ai_draw_accept in 1 (valid with ai_done).
REQ-010 SHALL have ports: chk_start out 1 and ai_start out 1, each a 1-cycle start strobe.
REQ-011 SHALL have ports: status out 13, 1-cycle pulses to the LED status block, bit-mapped by REQ-013.

Function
REQ-012 SHALL act only on rising edges of the button inputs, detected against a 1-cycle-delayed copy; a held button produces one action.
REQ-013 SHALL map status bits as: 0 black_to_play, 1 white_to_play, 2 draw_offer, 3 black_wins, 4 white_wins, 5 draw_game, 6 normal_wait, 7 player_must_jump, 8 more_jumps_available, 9 unrecoverable_error, 10 did_not_move, 11 new_game, 12 user_turn_done.
REQ-014 SHALL register all outputs; each pulse is high exactly 1 cycle, the cycle after the triggering event.
REQ-015 SHALL implement the states IDLE, START, HUMAN_WAIT, HUMAN_CHECK, AI_WAIT, OVER, FAULT; human plays black, AI plays white.
REQ-016 In IDLE, OVER and FAULT, a new_game edge SHALL pulse new_game and go to START.
REQ-017 START SHALL last 1 cycle, pulse black_to_play and normal_wait, and go to HUMAN_WAIT.
REQ-018 In HUMAN_WAIT, a turn_done edge SHALL pulse user_turn_done and chk_start and go to HUMAN_CHECK.
REQ-019 In HUMAN_WAIT, a draw edge SHALL pulse draw_offer and set draw_pending; simultaneous turn_done and draw edges SHALL give both actions in the same cycle.
REQ-020 In HUMAN_CHECK, on chk_done with result OK: a nonzero game_result SHALL pulse the matching win or draw bit and go to OVER; otherwise SHALL pulse white_to_play and ai_start, clear the timer and go to AI_WAIT.
REQ-021 In HUMAN_CHECK: NO_MOVE SHALL pulse did_not_move, MUST_JUMP SHALL pulse player_must_jump, and MORE_JUMPS SHALL pulse more_jumps_available, each returning to HUMAN_WAIT; ILLEGAL SHALL pulse unrecoverable_error and go to FAULT.
REQ-022 In AI_WAIT, on ai_done: draw_pending with ai_draw_accept SHALL pulse draw_game and go to OVER; otherwise a nonzero game_result SHALL pulse its result bit and go to OVER; otherwise SHALL pulse black_to_play and normal_wait and go to HUMAN_WAIT; draw_pending SHALL clear on any ai_done.
REQ-023 In AI_WAIT, the timer SHALL increment each cycle; reaching AI_TIMEOUT-1 without ai_done SHALL pulse unrecoverable_error and go to FAULT; ai_done in that same cycle SHALL win.
REQ-024 A new_game edge in START, HUMAN_WAIT, HUMAN_CHECK or AI_WAIT SHALL abort to START with a new_game pulse, overriding same-cycle chk_done or ai_done, and SHALL clear draw_pending and the timer.
REQ-025 chk_done outside HUMAN_CHECK and ai_done outside AI_WAIT SHALL be ignored.

Reset
REQ-026 rst SHALL force IDLE, all outputs 0, draw_pending 0, timer 0 and the button history to 0; rst SHALL take priority over all inputs, including mid-game.
REQ-027 A button held high through reset release SHALL NOT trigger an action until it is released and pressed again.

Structure
REQ-028 A shared package SHALL hold the state enum, the chk_result and game_result codes, and the status bit indices.
REQ-029 The design SHALL contain one sub-module, btn_edge, a registered rising-edge detector with synchronous reset, instanced three times.

Verification
REQ-030 Test: reset, then a new_game edge -> new_game pulse, next cycle black_to_play and normal_wait, and state HUMAN_WAIT.
REQ-031 Test: turn_done edge, then chk_done with result 2 -> user_turn_done and chk_start, then player_must_jump, back to HUMAN_WAIT, and no white_to_play.
REQ-032 Test: draw and turn_done edges in the same cycle, chk OK, then ai_done with ai_draw_accept=1 -> draw_offer and user_turn_done together, then white_to_play and ai_start, then draw_game, and state OVER.
REQ-033 Test: AI_TIMEOUT=8, enter AI_WAIT with no ai_done -> unrecoverable_error 8 cycles after ai_start, and state FAULT; a later ai_done is ignored.
REQ-034 Test: new_game edge in the same cycle as chk_done in HUMAN_CHECK -> only the new_game pulse, then START behaviour.
REQ-035 Test: rst asserted in AI_WAIT with turn_done_btn held -> all outputs 0 and IDLE; no action until the button is re-pressed.
